// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU/flag unit between two requesters.
// Define ALU_ARB_B2B_EN to let a waiting requester be granted straight out of RESP.
module alu_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int FLAGW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [FLAGW-1:0] alu_flags,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] rdata,
    output logic [FLAGW-1:0] rflags,
    output logic             busy,
    output logic             gnt_id
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, next_state;
    logic   ptr;
    logic   winner;
    logic   load;
    logic   load_id;

    // Sole requester wins outright; on contention the round-robin pointer decides.
    always_comb begin
        winner = ptr;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_id    = winner;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    load       = 1'b1;
                    load_id    = winner;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
`ifdef ALU_ARB_B2B_EN
                // The other requester is waiting: hand it the ALU without an idle bubble.
                if (req[~gnt_id]) begin
                    load       = 1'b1;
                    load_id    = ~gnt_id;
                    next_state = EXEC;
                end
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operands are captured once per grant so requesters may change them afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            gnt_id   <= 1'b0;
            rdata    <= '0;
            rflags   <= '0;
            ptr      <= 1'b0;
        end else begin
            if (load) begin
                alu_a    <= load_id ? a1 : a0;
                alu_b    <= load_id ? b1 : b0;
                alu_ctrl <= load_id ? op1 : op0;
                gnt_id   <= load_id;
            end
            if (state == EXEC) begin
                rdata  <= alu_result;
                rflags <= alu_flags;
            end
            if (state == RESP) begin
                ptr <= ~gnt_id;
            end
        end
    end

    assign ack  = (state == RESP) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small behavioural ALU/flag model.
module tb_alu_share_arbiter;

    localparam int WIDTH = 16;
    localparam int FLAGW = 5;
`ifdef ALU_ARB_B2B_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 3;
`endif

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       op0, op1;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [1:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic [FLAGW-1:0] alu_flags;
    logic [1:0]       ack;
    logic [WIDTH-1:0] rdata;
    logic [FLAGW-1:0] rflags;
    logic             busy;
    logic             gnt_id;

    int checkCount;
    int passCount;

    alu_share_arbiter #(.WIDTH(WIDTH), .FLAGW(FLAGW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a0         (a0),
        .b0         (b0),
        .op0        (op0),
        .a1         (a1),
        .b1         (b1),
        .op1        (op1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .ack        (ack),
        .rdata      (rdata),
        .rflags     (rflags),
        .busy       (busy),
        .gnt_id     (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 00 add, 01 sub, 10 and, 11 or; flags {EQ,N,Z,C,V}
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             carry, ovf;
    always_comb begin
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (alu_ctrl)
            2'b00: begin
                sum   = {1'b0, alu_a} + {1'b0, alu_b};
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            2'b01: begin
                sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            2'b10: res = alu_a & alu_b;
            default: res = alu_a | alu_b;
        endcase
        alu_result = res;
        alu_flags  = {alu_a == alu_b, res[WIDTH-1], res == '0, carry, ovf};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] op);
        if (sel) begin
            a1  = a;
            b1  = b;
            op1 = op;
        end else begin
            a0  = a;
            b0  = b;
            op0 = op;
        end
    endtask

    // Advances negedge by negedge until ack is seen; seen stays 0 on timeout.
    task automatic waitAck(input int budget, output logic [1:0] seen, output int cycles);
        seen   = 2'b00;
        cycles = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                seen   = ack;
                cycles = n;
                break;
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [1:0] seenAck;
    int         gap;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst = 1'b1;
        req = 2'b00;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 2'b00);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 2'b00);
        @(negedge clk);
        checkOutput("rst_outputs", {alu_a, alu_b}, 32'h0);
        checkOutput("rst_ctrl_ack_busy_gnt", {alu_ctrl, ack, busy, gnt_id}, 32'h0);
        checkOutput("rst_rdata_rflags", {rdata, 11'h0, rflags}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Add overflow from requester 0
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 2'b00);
        req = 2'b01;
        @(negedge clk);
        checkOutput("t1_busy_gnt", {busy, gnt_id}, 32'h2);
        checkOutput("t1_operands", {alu_a, alu_b}, 32'h7FFF0001);
        waitAck(5, seenAck, gap);
        checkOutput("t1_ack", seenAck, 32'h1);
        checkOutput("t1_latency", gap, 32'd1);
        checkOutput("t1_rdata", rdata, 32'h8000);
        checkOutput("t1_rflags", rflags, 32'h09);
        req = 2'b00;
        @(negedge clk);
        checkOutput("t1_ack_single_cycle", ack, 32'h0);

        // Subtract to zero from requester 1
        applyStimulus(1'b1, 16'h0005, 16'h0005, 2'b01);
        req = 2'b10;
        @(negedge clk);
        checkOutput("t2_busy_gnt", {busy, gnt_id}, 32'h3);
        waitAck(5, seenAck, gap);
        checkOutput("t2_ack", seenAck, 32'h2);
        checkOutput("t2_rdata", rdata, 32'h0000);
        checkOutput("t2_rflags", rflags, 32'h16);
        checkOutput("t2_gnt_in_resp", gnt_id, 32'h1);
        req = 2'b00;

        // Both held: strict alternation, gap depends on back-to-back mode
        doReset();
        applyStimulus(1'b0, 16'h0003, 16'h0004, 2'b00);
        applyStimulus(1'b1, 16'h00F0, 16'h0F0F, 2'b11);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            waitAck(8, seenAck, gap);
            checkOutput($sformatf("t3_ack_%0d", i), seenAck, (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("t3_rdata_%0d", i), rdata, (i % 2 == 0) ? 32'h0007 : 32'h0FFF);
            checkOutput($sformatf("t3_gap_%0d", i), gap, (i == 0) ? 32'd2 : EXP_GAP);
        end
        req = 2'b00;
        @(negedge clk);

        // Operands changed and req dropped after grant
        applyStimulus(1'b0, 16'h1234, 16'h1111, 2'b01);
        req = 2'b01;
        @(negedge clk);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 2'b10);
        req = 2'b00;
        waitAck(5, seenAck, gap);
        checkOutput("t4_ack", seenAck, 32'h1);
        checkOutput("t4_rdata", rdata, 32'h0123);
        @(negedge clk);

        // Reset in EXEC; pointer is 1 here, so the reset must clear it
        applyStimulus(1'b0, 16'h0010, 16'h0020, 2'b00);
        req = 2'b01;
        @(negedge clk);
        checkOutput("t5_in_exec", busy, 32'h1);
        rst = 1'b1;
        req = 2'b00;
        #1;
        checkOutput("t5_abort_ack_busy_gnt", {ack, busy, gnt_id}, 32'h0);
        checkOutput("t5_abort_operands", {alu_a, alu_b}, 32'h0);
        checkOutput("t5_abort_rdata", {rdata, 14'h0, alu_ctrl}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_no_ack_after", ack, 32'h0);
        applyStimulus(1'b0, 16'h0003, 16'h0004, 2'b00);
        applyStimulus(1'b1, 16'h00AA, 16'h0055, 2'b10);
        req = 2'b11;
        waitAck(5, seenAck, gap);
        checkOutput("t5_ptr_reset_ack", seenAck, 32'h1);
        req = 2'b00;
        @(negedge clk);
        req = 2'b10;
        waitAck(5, seenAck, gap);
        checkOutput("t5_req1_ack", seenAck, 32'h2);
        checkOutput("t5_req1_rdata", rdata, 32'h0000);
        req = 2'b00;

        // Idle: nothing moves
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_idle_%0d", i), {busy, ack, alu_ctrl, alu_a, alu_b}, {3'b000, 2'b10, 16'h00AA, 16'h0055});
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 16-bit ALU and its 5-bit flag unit between two requesters, e.g. two issue lanes.
- Round-robin arbitration; the block registers the operands into the ALU and registers the result and flags back out.
- Returns the result and flags to the winner with a one-cycle ack pulse.
- Sits between the requesting pipeline stages and the ALU/flags pair.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- FLAGW, 5, flag vector width, ordered {EQ,N,Z,C,V}.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  request per requester; held high until ack
- a0, b0  in  WIDTH  requester 0 operands
- op0  in  2  requester 0 ALU control
- a1, b1  in  WIDTH  requester 1 operands
- op1  in  2  requester 1 ALU control
- alu_a, alu_b  out  WIDTH  registered operands to the ALU
- alu_ctrl  out  2  registered ALU control
- alu_result  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_ctrl
- alu_flags  in  FLAGW  flag unit output {EQ,N,Z,C,V}
- ack  out  2  one-cycle completion pulse, one-hot
- rdata  out  WIDTH  result, valid while ack != 0
- rflags  out  FLAGW  flags, valid while ack != 0
- busy  out  1  high in EXEC and RESP
- gnt_id  out  1  requester currently owning the ALU

Behaviour:
- Reset: state=IDLE, ptr=0, all outputs 0 (alu_a, alu_b, alu_ctrl, ack, rdata, rflags, busy, gnt_id).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req==00, stay in IDLE.
  - Otherwise pick the winner: if only one req is set, that requester; if both are set, requester ptr.
  - Latch the winner's a/b/op into alu_a/alu_b/alu_ctrl, set gnt_id=winner, go to EXEC.
- EXEC: capture alu_result into rdata and alu_flags into rflags, go to RESP.
- RESP:
  - ack[gnt_id]=1 for exactly this cycle.
  - ptr <= ~gnt_id.
  - Next state is IDLE (see Optional Feature).
- Latency: req sampled high in IDLE at edge N -> ack high in cycle N+2. Throughput is one op per 3 cycles.
- Requester handshake: drop req or present new operands in the cycle after ack. In RESP the granted requester's req is ignored.
- Operands are captured once. Changing a/b/op or dropping req after the grant does not affect the transaction, and the ack is still issued.
- rdata/rflags hold their last value outside RESP; consumers use them only with ack.
- alu_a/alu_b/alu_ctrl hold between transactions (no toggling while idle).
- Both requests held continuously: grants strictly alternate 0,1,0,1...
- A single requester held continuously is re-granted every 3 cycles, with no starvation penalty.
- Reset mid-operation (EXEC or RESP): abort immediately, no ack, all state returns to reset values.
- Flags are passed through unmodified; the block does not interpret ALU control encodings.

Optional Feature:
- Macro: ALU_ARB_B2B_EN.
- Defined:
  - In RESP, if req[~gnt_id]==1, latch that requester's operands and go directly to EXEC with gnt_id=~gnt_id.
  - The ack for the finishing transaction still pulses in that same cycle.
  - Alternating traffic reaches one op per 2 cycles.
- Not defined: RESP always goes to IDLE; throughput is one op per 3 cycles.

Test Plan:
- rst, then req=01, a0=0x7FFF, b0=0x0001, op0=00 (add) -> ack=01 two cycles after grant, rdata=0x8000, rflags[3]=N=1, rflags[0]=V=1, rflags[2]=Z=0.
- req=10, a1=0x0005, b1=0x0005, op1=01 (sub) -> ack=10, rdata=0x0000, rflags[2]=Z=1, gnt_id=1 during busy.
- req=11 held for 4 transactions, ptr=0 after reset -> ack sequence 01,10,01,10. Without ALU_ARB_B2B_EN, acks are 3 cycles apart; with it, 2 cycles apart.
- req=01 granted, then a0/b0/op0 changed and req dropped in EXEC -> ack=01 still occurs and rdata reflects the originally captured operands.
- Assert rst during EXEC -> ack stays 00, busy=0, all outputs 0 immediately. The next req=10 is granted to requester 1 (ptr=0 after reset, only req1 set).
- Idle check: req=00 for 10 cycles -> busy=0, ack=00, alu_a/alu_b/alu_ctrl unchanged.
